intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_pkg.sv | 37 +++
 rtl/phase_timer.sv | 22 ++
 rtl/intersection_ctrl.sv | 120 ++++++++++++
 tb/tb_intersection_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared state enumeration and lamp codes for the intersection controller.
// The WALK state only exists when PED_WALK_EN is defined.
package intersection_pkg;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_1  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED_2  = 3'd5
`ifdef PED_WALK_EN
      , WALK    = 3'd6
`endif
   } state_t;

   localparam logic [1:0] GREEN  = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] RED    = 2'd2;

   function automatic logic [1:0] ns_lamp(input state_t s);
      case (s)
         NS_GREEN:  ns_lamp = GREEN;
         NS_YELLOW: ns_lamp = YELLOW;
         default:   ns_lamp = RED;
      endcase
   endfunction

   function automatic logic [1:0] ew_lamp(input state_t s);
      case (s)
         EW_GREEN:  ew_lamp = GREEN;
         EW_YELLOW: ew_lamp = YELLOW;
         default:   ew_lamp = RED;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase countdown: loads a duration, steps down on tick, flags the final tick.
module phase_timer (
   input  logic       clock,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       tick,
   output logic [3:0] count,
   output logic       last
);

   always_ff @(posedge clock) begin
      if (load) begin
         count <= load_value;
      end else if (tick && (count > 4'd1)) begin
         count <= count - 4'd1;
      end
   end

   // Count never shows 0: the phase ends on the tick seen at count 1.
   assign last = tick && (count == 4'd1);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way traffic light controller with optional pedestrian walk phase.
// Define PED_WALK_EN to build the WALK state, request latch and ped_ack.
module intersection_ctrl
   import intersection_pkg::*;
#(
   parameter int unsigned GREEN_T  = 15,
   parameter int unsigned YELLOW_T = 5,
   parameter int unsigned ALLRED_T = 2,
   parameter int unsigned WALK_T   = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       ped_req,
   output logic       ped_ack,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic       walk,
   output logic [3:0] count,
   output logic [2:0] phase
);

   state_t     state;
   state_t     next_state;
   logic       last;
   logic       load;
   logic [3:0] load_value;

`ifdef PED_WALK_EN
   logic       pending;
   logic       enter_walk;
`endif

   function automatic logic [3:0] duration(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   duration = 4'(GREEN_T);
         NS_YELLOW, EW_YELLOW: duration = 4'(YELLOW_T);
`ifdef PED_WALK_EN
         WALK:                 duration = 4'(WALK_T);
`endif
         default:              duration = 4'(ALLRED_T);
      endcase
   endfunction

   always_comb begin
      next_state = NS_GREEN;
      case (state)
         NS_GREEN:  next_state = NS_YELLOW;
         NS_YELLOW: next_state = ALLRED_1;
         ALLRED_1:  next_state = EW_GREEN;
         EW_GREEN:  next_state = EW_YELLOW;
         EW_YELLOW: next_state = ALLRED_2;
`ifdef PED_WALK_EN
         ALLRED_2:  next_state = pending ? WALK : NS_GREEN;
`endif
         default:   next_state = NS_GREEN;
      endcase
   end

   // The timer reloads on the same edge the state changes, so count shows D..1.
   assign load       = reset | last;
   assign load_value = reset ? 4'(GREEN_T) : duration(next_state);

   phase_timer u_timer (
      .clock      (clock),
      .load       (load),
      .load_value (load_value),
      .tick       (tick),
      .count      (count),
      .last       (last)
   );

`ifdef PED_WALK_EN
   assign enter_walk = last && (state == ALLRED_2) && pending;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= NS_GREEN;
         ns_light <= GREEN;
         ew_light <= RED;
`ifdef PED_WALK_EN
         walk     <= 1'b0;
         pending  <= 1'b0;
         ped_ack  <= 1'b0;
`endif
      end else begin
         if (last) begin
            state    <= next_state;
            ns_light <= ns_lamp(next_state);
            ew_light <= ew_lamp(next_state);
`ifdef PED_WALK_EN
            walk     <= (next_state == WALK);
`endif
         end
`ifdef PED_WALK_EN
         // A request arriving as the walk starts is kept for the next cycle.
         if (enter_walk) begin
            pending <= ped_req;
            ped_ack <= ped_req;
         end else if (ped_req && !pending) begin
            pending <= 1'b1;
            ped_ack <= 1'b1;
         end else begin
            ped_ack <= 1'b0;
         end
`endif
      end
   end

`ifndef PED_WALK_EN
   logic [4:0] unused_bits;
   assign unused_bits = {ped_req, 4'(WALK_T)};
   assign walk        = 1'b0;
   assign ped_ack     = 1'b0;
`endif

   assign phase = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: fixed vector table, corner sequences and random
// traffic against a phase-list reference model. Honours PED_WALK_EN if defined.
module tb_intersection_ctrl;
   import intersection_pkg::*;

   localparam int GT = 3;
   localparam int YT = 2;
   localparam int AT = 1;
   localparam int WT = 2;
   localparam int P_WALK = 6;
`ifdef PED_WALK_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       ped_req = 1'b0;
   logic       ped_ack;
   logic [1:0] ns_light;
   logic [1:0] ew_light;
   logic       walk;
   logic [3:0] count;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   intersection_ctrl #(
      .GREEN_T  (GT),
      .YELLOW_T (YT),
      .ALLRED_T (AT),
      .WALK_T   (WT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .tick     (tick),
      .ped_req  (ped_req),
      .ped_ack  (ped_ack),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .walk     (walk),
      .count    (count),
      .phase    (phase)
   );

   always #5 clock = ~clock;

   // Reference model: position in the phase list (spec order 0..6) and ticks left.
   int m_ph = 0;
   int m_cnt = GT;
   bit m_pend = 1'b0;
   bit m_ack = 1'b0;

   function automatic int dur_of(input int ph);
      int d [7] = '{GT, YT, AT, GT, YT, AT, WT};
      return d[ph];
   endfunction

   function automatic int succ(input int ph, input bit pend);
      if (ph == P_WALK) return 0;
      if (ph == 5) return (PED_EN && pend) ? P_WALK : 0;
      return ph + 1;
   endfunction

   task automatic model_update(input bit r, input bit t, input bit p);
      bit adv;
      bit nxt_pend;
      if (r) begin
         m_ph = 0; m_cnt = GT; m_pend = 0; m_ack = 0;
      end else begin
         adv = t && (m_cnt == 1);
         nxt_pend = m_pend;
         if (adv && m_ph == 5 && PED_EN && m_pend) begin
            nxt_pend = p; m_ack = p;
         end else if (PED_EN && p && !m_pend) begin
            nxt_pend = 1; m_ack = 1;
         end else begin
            m_ack = 0;
         end
         if (adv) begin
            m_ph = succ(m_ph, m_pend);
            m_cnt = dur_of(m_ph);
         end else if (t) begin
            m_cnt = m_cnt - 1;
         end
         m_pend = nxt_pend;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit t, input bit p);
      reset = r; tick = t; ped_req = p;
      @(posedge clock);
      #1;
      model_update(r, t, p);
      chk("model_phase", int'(phase), m_ph);
      chk("model_count", int'(count), m_cnt);
      chk("model_ns", int'(ns_light), (m_ph == 0) ? 0 : (m_ph == 1) ? 1 : 2);
      chk("model_ew", int'(ew_light), (m_ph == 3) ? 0 : (m_ph == 4) ? 1 : 2);
      chk("model_walk", int'(walk), (m_ph == P_WALK) ? 1 : 0);
      chk("model_ack", int'(ped_ack), int'(m_ack));
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 1, 0);
         step(0, 0, 0);
      end
   endtask

   typedef struct {
      bit r; bit t; bit p;
      int ph; int cnt; int ns; int ew; int wk; int ack;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit t, input bit p, input int ph,
                               input int cnt, input int ns, input int ew);
      vec_t v;
      v.r = r; v.t = t; v.p = p; v.ph = ph; v.cnt = cnt;
      v.ns = ns; v.ew = ew; v.wk = 0; v.ack = 0;
      return v;
   endfunction

   vec_t vecs [15];

   initial begin
      vecs[0]  = mk(1, 0, 0, int'(NS_GREEN),  3, 0, 2);
      vecs[1]  = mk(0, 1, 0, int'(NS_GREEN),  2, 0, 2);
      vecs[2]  = mk(0, 0, 0, int'(NS_GREEN),  2, 0, 2);
      vecs[3]  = mk(0, 1, 0, int'(NS_GREEN),  1, 0, 2);
      vecs[4]  = mk(0, 1, 0, int'(NS_YELLOW), 2, 1, 2);
      vecs[5]  = mk(0, 1, 0, int'(NS_YELLOW), 1, 1, 2);
      vecs[6]  = mk(0, 1, 0, int'(ALLRED_1),  1, 2, 2);
      vecs[7]  = mk(0, 0, 0, int'(ALLRED_1),  1, 2, 2);
      vecs[8]  = mk(0, 1, 0, int'(EW_GREEN),  3, 2, 0);
      vecs[9]  = mk(0, 1, 0, int'(EW_GREEN),  2, 2, 0);
      vecs[10] = mk(0, 1, 0, int'(EW_GREEN),  1, 2, 0);
      vecs[11] = mk(0, 1, 0, int'(EW_YELLOW), 2, 2, 1);
      vecs[12] = mk(0, 1, 0, int'(EW_YELLOW), 1, 2, 1);
      vecs[13] = mk(0, 1, 0, int'(ALLRED_2),  1, 2, 2);
      vecs[14] = mk(0, 1, 0, int'(NS_GREEN),  3, 0, 2);

      step(1, 0, 0);
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].r, vecs[i].t, vecs[i].p);
         chk($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ph);
         chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
         chk($sformatf("vec%0d_ns", i), int'(ns_light), vecs[i].ns);
         chk($sformatf("vec%0d_ew", i), int'(ew_light), vecs[i].ew);
         chk($sformatf("vec%0d_walk", i), int'(walk), vecs[i].wk);
         chk($sformatf("vec%0d_ack", i), int'(ped_ack), vecs[i].ack);
         if (i == 9) begin
            for (int h = 0; h < 50; h++) begin
               step(0, 0, 0);
               chk("hold_count", int'(count), 2);
               chk("hold_ew", int'(ew_light), 0);
               chk("hold_ns", int'(ns_light), 2);
            end
         end
      end

      // Request during NS_GREEN: one ack, repeat press ignored.
      step(0, 0, 1);
      chk("ack_first", int'(ped_ack), int'(PED_EN));
      step(0, 0, 0);
      chk("ack_drop", int'(ped_ack), 0);
      step(0, 0, 1);
      chk("ack_second", int'(ped_ack), 0);
      step(0, 0, 0);
      tick_n(12);
`ifdef PED_WALK_EN
      chk("walk_phase", int'(phase), P_WALK);
      chk("walk_lamp", int'(walk), 1);
      chk("walk_count", int'(count), WT);
      chk("walk_ns", int'(ns_light), 2);
      chk("walk_ew", int'(ew_light), 2);
      tick_n(2);
      chk("after_walk_phase", int'(phase), int'(NS_GREEN));
      chk("after_walk_count", int'(count), GT);

      // Request on the ALLRED_2 -> WALK edge is kept for the next cycle.
      step(0, 0, 1);
      chk("ack_pend", int'(ped_ack), 1);
      tick_n(11);
      chk("pre_walk_phase", int'(phase), int'(ALLRED_2));
      step(0, 1, 1);
      chk("edge_phase", int'(phase), P_WALK);
      chk("edge_ack", int'(ped_ack), 1);
      step(0, 0, 0);
      chk("edge_ack_drop", int'(ped_ack), 0);
      tick_n(14);
      chk("rewalk_phase", int'(phase), P_WALK);
      chk("rewalk_lamp", int'(walk), 1);
`else
      chk("nowalk_phase", int'(phase), int'(NS_GREEN));
      chk("nowalk_lamp", int'(walk), 0);
      step(1, 0, 0);
      for (int k = 0; k < 24; k++) begin
         step(0, 1, 1);
         chk("held_req_ack", int'(ped_ack), 0);
         chk("held_req_walk", int'(walk), 0);
         chk("held_req_phase", int'(phase == 3'd6), 0);
         step(0, 0, 1);
      end
`endif

      // Reset on the final tick of EW_YELLOW with a request pending.
      step(1, 0, 0);
      step(0, 0, 1);
      tick_n(10);
      chk("ewy_phase", int'(phase), int'(EW_YELLOW));
      chk("ewy_count", int'(count), 1);
      step(1, 1, 1);
      chk("rst_phase", int'(phase), int'(NS_GREEN));
      chk("rst_count", int'(count), GT);
      chk("rst_ack", int'(ped_ack), 0);
      chk("rst_ns", int'(ns_light), 0);
      chk("rst_ew", int'(ew_light), 2);
      tick_n(12);
      chk("rst_pend_cleared", int'(phase), int'(NS_GREEN));
      chk("rst_pend_count", int'(count), GT);

      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
